// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for mem_arbiter: FSM state encoding and the round-robin search.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        s_Idle       = 2'b00,
        s_Granted    = 2'b01,
        s_Turnaround = 2'b10
    } arb_state_e;

    localparam int unsigned MaxCu = 32;

    // First set bit of req at or after start, wrapping modulo n; returns start when none is set.
    function automatic int unsigned rr_next_owner(input logic [MaxCu-1:0] req,
                                                  input int unsigned start,
                                                  input int unsigned n);
        int unsigned owner;
        int unsigned idx;
        logic found;
        owner = start;
        found = 1'b0;
        for (int unsigned i = 0; i < MaxCu; i++) begin
            if (i < n && !found) begin
                idx = (start + i) % n;
                if (req[idx]) begin
                    owner = idx;
                    found = 1'b1;
                end
            end
        end
        return owner;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first requester at or after start_i, wrapping.
module rr_priority_pick
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned num_cu     = 4,
    parameter int unsigned num_cu_log = 2
) (
    input  logic [num_cu-1:0]     req_i,
    input  logic [num_cu_log-1:0] start_i,
    output logic                  found_o,
    output logic [num_cu_log-1:0] winner_o
);

    logic [MaxCu-1:0] req_ext;

    always_comb begin
        req_ext = '0;
        req_ext[num_cu-1:0] = req_i;
    end

    assign found_o  = |req_i;
    assign winner_o = num_cu_log'(rr_next_owner(req_ext, 32'(start_i), num_cu));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the shared coprocessor data-memory port with burst-locked grants.
// Optional per-CU grant counters are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned num_cu          = 4,
    parameter int unsigned num_cu_log      = 2,
    parameter int unsigned memory_size_log = 10,
    parameter int unsigned count_width     = 16
) (
    input  logic                              i_Clock,
    input  logic                              i_Reset,
    input  logic [num_cu-1:0]                 i_Grant_Request,
    output logic [num_cu-1:0]                 o_Grant,
    output logic [num_cu_log-1:0]             o_Grant_Index,
    output logic                              o_Busy,
    input  logic [num_cu*memory_size_log-1:0] i_CU_Memory_Address,
    input  logic [num_cu-1:0]                 i_CU_Memory_Read_Enable,
    input  logic [num_cu-1:0]                 i_CU_Memory_Write_Enable,
    output logic [memory_size_log-1:0]        o_Memory_Address,
    output logic                              o_Memory_Read_Enable,
    output logic                              o_Memory_Write_Enable,
`ifdef MEM_ARB_STATS_EN
    output logic [num_cu*count_width-1:0]     o_Grant_Count,
`endif
    output logic                              o_Violation
);

    if (num_cu < 2 || (1 << num_cu_log) < num_cu || count_width == 0) begin : g_bad_cfg
        $error("mem_arbiter: invalid parameter combination");
    end

    arb_state_e                state_q;
    logic [num_cu-1:0]         grant_q;
    logic [num_cu_log-1:0]     grant_index_q;
    logic [num_cu_log-1:0]     last_owner_q;
    logic                      busy_q;
    logic                      violation_q;

    logic [num_cu_log-1:0]     start_index;
    logic                      pick_found;
    logic [num_cu_log-1:0]     pick_index;
    logic                      owner_req;
    logic                      stray_enable;

    assign start_index = (last_owner_q == num_cu_log'(num_cu - 1)) ? '0
                                                                   : last_owner_q + 1'b1;

    rr_priority_pick #(
        .num_cu     (num_cu),
        .num_cu_log (num_cu_log)
    ) u_pick (
        .req_i    (i_Grant_Request),
        .start_i  (start_index),
        .found_o  (pick_found),
        .winner_o (pick_index)
    );

    // Memory port mux; everything is driven low unless a burst is in progress.
    always_comb begin
        owner_req             = 1'b0;
        o_Memory_Address      = '0;
        o_Memory_Read_Enable  = 1'b0;
        o_Memory_Write_Enable = 1'b0;
        for (int i = 0; i < int'(num_cu); i++) begin
            if (num_cu_log'(i) == grant_index_q) begin
                owner_req = i_Grant_Request[i];
                if (state_q == s_Granted) begin
                    o_Memory_Address      = i_CU_Memory_Address[i*memory_size_log +: memory_size_log];
                    o_Memory_Read_Enable  = i_CU_Memory_Read_Enable[i];
                    o_Memory_Write_Enable = i_CU_Memory_Write_Enable[i];
                end
            end
        end
    end

    always_comb begin
        stray_enable = 1'b0;
        for (int i = 0; i < int'(num_cu); i++) begin
            if ((i_CU_Memory_Read_Enable[i] || i_CU_Memory_Write_Enable[i]) &&
                (state_q != s_Granted || num_cu_log'(i) != grant_index_q)) begin
                stray_enable = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            state_q       <= s_Idle;
            grant_q       <= '0;
            grant_index_q <= '0;
            last_owner_q  <= num_cu_log'(num_cu - 1);
            busy_q        <= 1'b0;
            violation_q   <= 1'b0;
        end else begin
            violation_q <= violation_q | stray_enable;
            case (state_q)
                s_Idle: begin
                    if (pick_found) begin
                        state_q       <= s_Granted;
                        grant_q       <= {{(num_cu-1){1'b0}}, 1'b1} << pick_index;
                        grant_index_q <= pick_index;
                        last_owner_q  <= pick_index;
                        busy_q        <= 1'b1;
                    end
                end
                s_Granted: begin
                    if (!owner_req) begin
                        state_q <= s_Turnaround;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                s_Turnaround: state_q <= s_Idle;
                default:      state_q <= s_Idle;
            endcase
        end
    end

    assign o_Grant       = grant_q;
    assign o_Grant_Index = grant_index_q;
    assign o_Busy        = busy_q;
    assign o_Violation   = violation_q;

`ifdef MEM_ARB_STATS_EN
    logic [count_width-1:0] count_q [num_cu];

    always_ff @(posedge i_Clock) begin
        if (!i_Reset) begin
            for (int i = 0; i < int'(num_cu); i++) begin
                count_q[i] <= '0;
            end
        end else if (state_q == s_Idle && pick_found) begin
            for (int i = 0; i < int'(num_cu); i++) begin
                if (num_cu_log'(i) == pick_index && count_q[i] != '1) begin
                    count_q[i] <= count_q[i] + count_width'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < int'(num_cu); g++) begin : g_count_out
        assign o_Grant_Count[g*count_width +: count_width] = count_q[g];
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus hand-written multi-cycle sequences.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [1:0]  grant_idx;
    logic        busy;
    logic [39:0] cu_addr;
    logic [3:0]  cu_re;
    logic [3:0]  cu_we;
    logic [9:0]  mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic        viol;
`ifdef MEM_ARB_STATS_EN
    logic [63:0] grant_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(
        .num_cu          (4),
        .num_cu_log      (2),
        .memory_size_log (10),
        .count_width     (16)
    ) dut (
        .i_Clock                  (clk),
        .i_Reset                  (rst_n),
        .i_Grant_Request          (req),
        .o_Grant                  (grant),
        .o_Grant_Index            (grant_idx),
        .o_Busy                   (busy),
        .i_CU_Memory_Address      (cu_addr),
        .i_CU_Memory_Read_Enable  (cu_re),
        .i_CU_Memory_Write_Enable (cu_we),
        .o_Memory_Address         (mem_addr),
        .o_Memory_Read_Enable     (mem_re),
        .o_Memory_Write_Enable    (mem_we),
`ifdef MEM_ARB_STATS_EN
        .o_Grant_Count            (grant_count),
`endif
        .o_Violation              (viol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] re;
        logic [3:0] we;
        logic [3:0] grant;
        logic [1:0] idx;
        logic       busy;
        logic [9:0] addr;
        logic       mre;
        logic       mwe;
        logic       viol;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic grant_once(input int n);
        @(negedge clk);
        req = 4'b0001 << n;
        tick();
        @(negedge clk);
        req = 4'b0000;
        repeat (2) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[5];
        int gap;
        int owner;

        exp_order = '{0, 1, 2, 3, 0};
        vecs[0]  = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b1, 10'h155, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 10'h155, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 10'h155, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'b0011, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1, 10'h011, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'b0011, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 10'h011, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b1, 10'h0AA, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'b0011, 4'b0000, 4'b0010, 4'b0010, 2'd1, 1'b1, 10'h0AA, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1, 10'h011, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{4'b0001, 4'b0000, 4'b1000, 4'b0001, 2'd0, 1'b1, 10'h011, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1, 10'h011, 1'b0, 1'b0, 1'b1};

        rst_n   = 1'b0;
        req     = '0;
        cu_re   = '0;
        cu_we   = '0;
        cu_addr = {10'h3C3, 10'h155, 10'h0AA, 10'h011};
        repeat (2) tick();
        chk("reset_grant", 32'(grant), 32'h0);
        chk("reset_index", 32'(grant_idx), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_addr", 32'(mem_addr), 32'h0);
        chk("reset_viol", 32'(viol), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 16; v++) begin
            @(negedge clk);
            req   = vecs[v].req;
            cu_re = vecs[v].re;
            cu_we = vecs[v].we;
            tick();
            chk($sformatf("vec%0d_grant", v), 32'(grant), 32'(vecs[v].grant));
            chk($sformatf("vec%0d_index", v), 32'(grant_idx), 32'(vecs[v].idx));
            chk($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].busy));
            chk($sformatf("vec%0d_addr", v), 32'(mem_addr), 32'(vecs[v].addr));
            chk($sformatf("vec%0d_mem_re", v), 32'(mem_re), 32'(vecs[v].mre));
            chk($sformatf("vec%0d_mem_we", v), 32'(mem_we), 32'(vecs[v].mwe));
            chk($sformatf("vec%0d_viol", v), 32'(viol), 32'(vecs[v].viol));
        end

        // Reset during CU2's burst, then 0110 must go to CU1.
        @(negedge clk);
        req   = 4'b0100;
        cu_re = 4'b0000;
        cu_we = 4'b0000;
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("midrst_pre_grant", 32'(grant), 32'h4);
        @(negedge clk);
        cu_re = 4'b0100;
        rst_n = 1'b0;
        tick();
        chk("midrst_grant", 32'(grant), 32'h0);
        chk("midrst_index", 32'(grant_idx), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_addr", 32'(mem_addr), 32'h0);
        chk("midrst_mem_re", 32'(mem_re), 32'h0);
        chk("midrst_viol", 32'(viol), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cu_re = 4'b0000;
        req   = 4'b0110;
        tick();
        chk("postrst_grant", 32'(grant), 32'h2);
        chk("postrst_index", 32'(grant_idx), 32'h1);

        // Round-robin with all four requesting, each releasing after 3 granted cycles.
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            gap = 0;
            while (grant == 4'b0000 && gap < 10) begin
                tick();
                gap++;
            end
            chk($sformatf("rr%0d_index", k), 32'(grant_idx), 32'(exp_order[k]));
            chk($sformatf("rr%0d_grant", k), 32'(grant), 32'(4'b0001 << exp_order[k]));
            if (k > 0) chk($sformatf("rr%0d_gap", k), 32'(gap), 32'd2);
            owner = int'(grant_idx);
            repeat (2) tick();
            chk($sformatf("rr%0d_held", k), 32'(grant), 32'(4'b0001 << exp_order[k]));
            @(negedge clk);
            req[owner] = 1'b0;
            tick();
            chk($sformatf("rr%0d_release", k), 32'(grant), 32'h0);
            @(negedge clk);
            req = 4'b1111;
        end

`ifdef MEM_ARB_STATS_EN
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) grant_once(0);
        for (int i = 0; i < 2; i++) grant_once(3);
        chk("stats_cu0", 32'(grant_count[15:0]), 32'd5);
        chk("stats_cu1", 32'(grant_count[31:16]), 32'd0);
        chk("stats_cu2", 32'(grant_count[47:32]), 32'd0);
        chk("stats_cu3", 32'(grant_count[63:48]), 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single coprocessor data-memory port among `num_cu` tile control units. Each CU raises a grant request, holds it for a complete read burst (A/B fetch) or write burst (C store), and drops it when done. The arbiter grants exactly one CU at a time, locks the grant for the whole burst, and muxes the winner's address and enables onto the memory port. It sits between the CU array and the memory, alongside the main CU.

## Interface
Parameters:
- `num_cu`, 4: number of requesting control units; must be 2 or more.
- `num_cu_log`, 2: ceil(log2(`num_cu`)).
- `memory_size_log`, 10: memory address width.
- `count_width`, 16: width of each per-CU grant counter (used only with `MEM_ARB_STATS_EN`).

Ports:
- `i_Clock`, in, 1: the single clock. All logic is rising-edge.
- `i_Reset`, in, 1: **reset is synchronous and active-low**. It is sampled on the rising edge of `i_Clock`.
- `i_Grant_Request`, in, `num_cu`: request bit per CU, level-held for the whole burst.
- `o_Grant`, out, `num_cu`: one-hot or zero grant, registered.
- `o_Grant_Index`, out, `num_cu_log`: index of the current owner. Holds the last owner when idle.
- `o_Busy`, out, 1: high while any grant is active.
- `i_CU_Memory_Address`, in, `num_cu*memory_size_log`: packed addresses; CU n occupies bits `[n*memory_size_log +: memory_size_log]`.
- `i_CU_Memory_Read_Enable`, in, `num_cu`: per-CU read enable.
- `i_CU_Memory_Write_Enable`, in, `num_cu`: per-CU write enable.
- `o_Memory_Address`, out, `memory_size_log`: muxed address to memory.
- `o_Memory_Read_Enable`, out, 1: muxed read enable.
- `o_Memory_Write_Enable`, out, 1: muxed write enable.
- `o_Violation`, out, 1: sticky flag. Set when a non-owner drives a read or write enable.
- `o_Grant_Count`, out, `num_cu*count_width`: packed per-CU grant counters. Present only with `MEM_ARB_STATS_EN`.

## Operation
States:
- `s_Idle`: no grant. If any request bit is set, pick the winner and go to `s_Granted`.
- `s_Granted`: stay here while `i_Grant_Request[owner]` is high. When it drops, clear `o_Grant` and go to `s_Turnaround`.
- `s_Turnaround`: one dead cycle, then go to `s_Idle`.

Arbitration rules:
- Search order starts at `(last_owner+1) mod num_cu` and wraps around.
- After reset, `last_owner` is `num_cu-1`, so CU0 has first priority.
- Other requests have no effect while a grant is held; a burst is never preempted.
- The winner's request must still be high on the arbitration edge. A request that pulses for one cycle in `s_Idle` is granted only if it is high on that edge.

Memory mux:
- Combinational, selected by the owner.
- Outside `s_Granted`, both memory enables are forced to 0 and the address is forced to 0.
- The address is passed through without modification.

Violation detection:
- `o_Violation` is set on any edge where a CU other than the owner has its read or write enable high.
- Outside `s_Granted`, any CU with an enable high sets it.
- Once set, it stays set until reset.

Simultaneous events:
- The owner dropping its request while others are requesting always costs the turnaround cycle. No back-to-back handover is allowed.
- If the owner raises read and write enables together, both pass to memory. Memory defines the result; this is not flagged.

Reset:
- On reset all outputs go low: `o_Grant`=0, `o_Grant_Index`=0, `o_Busy`=0, `o_Memory_*`=0, `o_Violation`=0, counters=0. The state returns to `s_Idle`.
- Reset in the middle of a burst drops the grant on the same edge.

## Timing
- Request high at edge t (arbiter idle) → `o_Grant` and `o_Busy` high after edge t+1. Latency is 1 cycle.
- Memory signals follow the owner's inputs in the same cycle (zero latency) while granted.
- Request low at edge t → `o_Grant` low after edge t+1, then one turnaround cycle. The next grant is earliest after edge t+3.
- Minimum spacing between two grants is therefore 2 grant-free cycles.

## Configuration
- `MEM_ARB_STATS_EN` defined:
  - Instantiates `num_cu` counters of `count_width` bits.
  - Counter n increments by 1 on each transition `s_Idle`→`s_Granted` with owner n.
  - Counters saturate at all-ones.
- `MEM_ARB_STATS_EN` undefined:
  - Counters and the `o_Grant_Count` port are absent.
  - All other behaviour is identical.

## Structure
- Shared package holds:
  - the state encoding constants `s_Idle`=2'b00, `s_Granted`=2'b01, `s_Turnaround`=2'b10;
  - the function that returns the round-robin next owner.
- One natural sub-module is `rr_priority_pick`:
  - combinational;
  - inputs: request vector and start index;
  - outputs: found flag and winner index.
- The FSM, mux, violation logic and counters live in `mem_arbiter`.

## Test plan
- **Single request:** `i_Grant_Request`=4'b0100 → `o_Grant`=4'b0100 and `o_Grant_Index`=2 one cycle later. `o_Memory_Address` equals CU2's address 0x155.
- **Round-robin:** after reset, requests 4'b1111 held and each CU releases after 3 cycles → grant order 0,1,2,3,0. Each handover has exactly 2 grant-free cycles.
- **No preemption:** CU1 is granted; CU0 raises its request mid-burst → CU1 keeps the grant until it drops its request. CU0 is granted only after the turnaround cycle.
- **Violation:** CU1 is granted; CU3 raises `i_CU_Memory_Write_Enable` → `o_Violation`=1 and stays 1. `o_Memory_Write_Enable` follows CU1 only.
- **Reset mid-burst:** `i_Reset`=0 during CU2's grant → on the next edge all outputs are 0. After release, request 4'b0110 → CU1 wins.
- **Stats (`MEM_ARB_STATS_EN`):** 5 grants to CU0 and 2 to CU3 → `o_Grant_Count` slot 0 = 5, slot 3 = 2, others 0.
